// File: rtl/ifu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ifu_pkg
// Brief   : Shared widths, NOP encoding and entry types for the fetch unit.
// Revision: 1.0 - initial release
// ============================================================================
package ifu_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } buf_entry_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            kill;
    } tag_entry_t;

endpackage
`default_nettype wire

// File: rtl/ifu_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module  : ifu_sync_fifo
// Brief   : Synchronous FIFO with clear and occupancy count (instruction buffer).
// Revision: 1.0 - initial release
// ============================================================================
module ifu_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push = push && (r_count != (AW+1)'(DEPTH));
    assign w_pop  = pop && (r_count != '0);

    // Clear wins over any same-cycle push/pop so the FIFO always ends empty.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= push_data;
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign count    = r_count;

endmodule
`default_nettype wire

// File: rtl/ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ifu_fetch_ctrl
// Brief   : Fetch request/credit control, PC-tagging of responses and decode
//           buffer. Define IFU_PERF_CNT_EN to add fetch/stall perf counters.
// Revision: 1.0 - initial release
// ============================================================================
module ifu_fetch_ctrl #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            pc_en,
    input  logic            flush,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc
`ifdef IFU_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);

    import ifu_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    tag_entry_t    r_tag [DEPTH];
    logic [AW-1:0] r_tag_wr;
    logic [AW-1:0] r_tag_rd;
    logic [CW-1:0] r_tag_cnt;
    logic [CW-1:0] w_buf_cnt;
    logic [CW:0]   w_credit_used;
    logic          w_fire;
    logic          w_rsp;
    logic          w_rsp_keep;
    logic          w_pop;
    buf_entry_t    w_buf_in;
    buf_entry_t    w_buf_head;

    // Killed tags still hold credit until their responses drain.
    assign w_credit_used  = {1'b0, r_tag_cnt} + {1'b0, w_buf_cnt};
    assign imem_req_valid = !rst && !flush && (w_credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc;
    assign w_fire         = imem_req_valid && imem_req_ready;
    assign pc_en          = !rst && (w_fire || flush);

    assign w_rsp      = imem_rsp_valid && (r_tag_cnt != '0);
    assign w_rsp_keep = w_rsp && !r_tag[r_tag_rd].kill && !flush;
    assign w_buf_in   = '{pc: r_tag[r_tag_rd].pc, instr: imem_rsp_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_wr  <= '0;
            r_tag_rd  <= '0;
            r_tag_cnt <= '0;
        end else begin
            if (w_fire) r_tag_wr <= r_tag_wr + 1'b1;
            if (w_rsp)  r_tag_rd <= r_tag_rd + 1'b1;
            if (w_fire && !w_rsp)      r_tag_cnt <= r_tag_cnt + 1'b1;
            else if (w_rsp && !w_fire) r_tag_cnt <= r_tag_cnt - 1'b1;
        end
    end

    // Flush marks every slot killed at once; a same-cycle push inherits kill.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                r_tag[i] <= '0;
            end else if (w_fire && (r_tag_wr == AW'(i))) begin
                r_tag[i] <= '{pc: pc, kill: flush};
            end else if (flush) begin
                r_tag[i].kill <= 1'b1;
            end
        end
    end

    assign w_pop = id_valid && id_ready;

    ifu_sync_fifo #(
        .WIDTH ($bits(buf_entry_t)),
        .DEPTH (DEPTH)
    ) u_ibuf (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .push      (w_rsp_keep),
        .push_data (w_buf_in),
        .pop       (w_pop),
        .pop_data  (w_buf_head),
        .count     (w_buf_cnt)
    );

    assign id_valid = !rst && (w_buf_cnt != '0);
    assign id_instr = id_valid ? w_buf_head.instr : NOP_INSTR;
    assign id_pc    = id_valid ? w_buf_head.pc : '0;

`ifdef IFU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (w_pop) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if ((!flush && !imem_req_valid) || (imem_req_valid && !imem_req_ready))
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`else
    // Performance counters are compiled out in this build.
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(imem_rsp_valid && (r_tag_cnt == '0)))
                else $error("ifu_fetch_ctrl: response with no outstanding request");
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
Fetch controller sitting directly downstream of the PC register in the fetch stage.
- Issues instruction-memory read requests at the current PC.
- Drives pc_en so the PC register advances only when a request is accepted or a redirect occurs.
- Pairs in-order memory responses with their PCs and buffers them for decode under a valid/ready handshake.
- Supports flush/redirect, including discarding stale in-flight responses.

Parameters:
XLEN, 32, address/instruction width (only 32 supported)
DEPTH, 4, combined in-flight + buffered capacity; power of 2, >= 2

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
pc  in  XLEN  current PC from PC register
pc_en  out  1  PC register load enable
flush  in  1  redirect from execute; upstream next-PC mux selects target when set
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address (= pc)
imem_rsp_valid  in  1  response valid, in request order, always accepted
imem_rsp_data  in  32  fetched instruction
id_valid  out  1  instruction available to decode
id_ready  in  1  decode accepts
id_instr  out  32  instruction at buffer head
id_pc  out  XLEN  PC of id_instr

Behaviour:
Reset
- On rst, tag FIFO, instruction buffer and all counters are cleared.
- Output values during rst: pc_en=0, imem_req_valid=0, id_valid=0, id_instr=32'h00000013 (NOP), id_pc=0.
- Instruction memory shares rst; no responses are expected for pre-reset requests.

Credit
- tag_cnt = requests issued but not yet answered. buf_cnt = entries in the instruction buffer.
- imem_req_valid = !rst & !flush & (tag_cnt + buf_cnt < DEPTH).
- imem_req_addr = pc (combinational).

Request fire
- A request fires when imem_req_valid & imem_req_ready.
- On fire, push {pc, kill=0} into the tag FIFO.
- pc_en = fire | flush (combinational). The PC never advances without an accepted request, except on redirect.

Response
- Pop the head of the tag FIFO.
- If the popped entry has kill=1, discard the response.
- Otherwise write {tag_pc, imem_rsp_data} into the instruction buffer.
- Credit guarantees the buffer never overflows.
- Response-to-id_valid latency is 1 cycle (registered, no bypass).

Decode handshake
- id_valid = buf_cnt != 0; id_instr/id_pc come from the buffer head.
- Pop the buffer on id_valid & id_ready.
- id_instr = NOP and id_pc = 0 when not valid.

Flush
- Clear the instruction buffer (buf_cnt=0).
- Set kill=1 on every valid tag entry, including one being pushed that cycle. This cannot happen in practice, since no request issues during flush.
- tag_cnt is unchanged, so killed entries still consume credit until their responses return.

Simultaneous events
- Response and flush in the same cycle: the response is discarded.
- Decode pop and flush in the same cycle: the pop completes and the buffer ends empty.
- Request fire and response in the same cycle: tag_cnt is unchanged.
- Push and pop on the buffer in the same cycle: buf_cnt is unchanged.

Error
- imem_rsp_valid with tag_cnt=0 is illegal; flag with a simulation-only assertion.

Optional Feature:
Macro: IFU_PERF_CNT_EN
- Defined: adds outputs perf_fetch_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_fetch_cnt counts decode pops.
  - perf_stall_cnt counts cycles with !flush & !imem_req_valid, or imem_req_valid & !imem_req_ready.
  - Both are cleared on rst and wrap at 2^32.
- Undefined: ports and logic are absent; remaining behaviour is identical.

Decomposition:
- Package ifu_pkg holds:
  - XLEN
  - NOP_INSTR = 32'h00000013
  - a typedef for the buffer entry {pc, instr}
  - a typedef for the tag entry {pc, kill}
- Sub-module ifu_sync_fifo: parameterized width/depth, synchronous clear input, count output. Used for the instruction buffer.
- Tag FIFO is coded inline, because flush must update all kill bits in parallel.

Test Plan:
- Reset release, pc=0x0, imem_req_ready=1, single-cycle memory, id_ready=1. Expected:
  - requests to 0x0, 0x4, 0x8 on consecutive cycles;
  - pc_en=1 on each;
  - id_valid with id_pc=0x0 one cycle after the first response.
- id_ready=0 with memory always ready. Expected:
  - exactly DEPTH=4 requests issued;
  - imem_req_valid=0 and pc_en=0 thereafter;
  - on releasing id_ready, instructions drain in order 0x0..0xC.
- imem_req_ready=0 for 5 cycles. Expected: pc_en=0, pc held, no tag pushed; the next fire occurs at the held pc.
- Two requests in flight (0x10, 0x14), then flush with target 0x100. Expected:
  - both responses discarded;
  - id_valid stays 0 until the response for 0x100 arrives;
  - id_pc=0x100.
- Flush in the same cycle as a response, and flush in the same cycle as a decode pop. Expected: buffer empty next cycle, stale data never presented.
- Assert rst while 3 entries are buffered and 1 is in flight. Expected: all outputs return to reset values next cycle, and the fetch sequence restarts cleanly.
